// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: widths, state encoding, PC increment.
`include "defines.sv"

package fetch_pkg;
    localparam int ADDRESS_LEN     = `ADDRESS_LEN;
    localparam int INSTRUCTION_LEN = `INSTRUCTION_LEN;

    typedef logic [ADDRESS_LEN-1:0]     addr_t;
    typedef logic [INSTRUCTION_LEN-1:0] instr_t;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

    // Wraps naturally at the address width: all-ones + 1 gives zero.
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction
endpackage

// File: rtl/defines.sv
// Global datapath widths shared by the fetch stage and its neighbours.
`ifndef FETCH_DEFINES_SV
`define FETCH_DEFINES_SV
`define ADDRESS_LEN     16
`define INSTRUCTION_LEN 32
`endif

// File: rtl/instruction_fetch.sv
// Fetch stage: drives instruction memory and presents (instruction, PC+1) to the IF/ID register,
// buffering a response that arrives while the pipeline is stalled.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter addr_t  RESET_PC  = '0,
    parameter instr_t NOP_INSTR = '0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   redirect,
    input  addr_t  redirect_target,
    output logic   imem_req,
    output addr_t  imem_addr,
    input  logic   imem_ready,
    input  instr_t imem_rdata,
    output addr_t  PC_plus1,
    output instr_t Instruction
);

    fetch_state_t r_state;
    addr_t        r_pc;
    instr_t       r_hold_instr;
    addr_t        r_hold_pc1;
    instr_t       r_last_instr;
    addr_t        r_last_pc1;

    fetch_state_t w_next_state;
    addr_t        w_next_pc;
    instr_t       w_next_hold_instr;
    addr_t        w_next_hold_pc1;
    instr_t       w_out_instr;
    addr_t        w_out_pc1;
    addr_t        w_pc_plus1;

    assign w_pc_plus1 = pc_inc(r_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc1   <= '0;
            r_last_instr <= NOP_INSTR;
            r_last_pc1   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_hold_instr <= w_next_hold_instr;
            r_hold_pc1   <= w_next_hold_pc1;
            r_last_instr <= w_out_instr;
            r_last_pc1   <= w_out_pc1;
        end
    end

    // Priority: redirect squashes everything, then stall holds, then normal fetch.
    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_hold_instr = r_hold_instr;
        w_next_hold_pc1   = r_hold_pc1;
        w_out_instr       = NOP_INSTR;
        w_out_pc1         = '0;
        if (redirect) begin
            w_next_pc         = redirect_target;
            w_next_state      = S_REQ;
            w_next_hold_instr = NOP_INSTR;
            w_next_hold_pc1   = '0;
        end else if (stall) begin
            w_out_instr = r_last_instr;
            w_out_pc1   = r_last_pc1;
            // A response landing during a stall is parked so the request is not repeated.
            if (r_state == S_REQ && imem_ready) begin
                w_next_hold_instr = imem_rdata;
                w_next_hold_pc1   = w_pc_plus1;
                w_next_state      = S_HOLD;
            end
        end else if (r_state == S_HOLD) begin
            w_out_instr  = r_hold_instr;
            w_out_pc1    = r_hold_pc1;
            w_next_pc    = w_pc_plus1;
            w_next_state = S_REQ;
        end else if (imem_ready) begin
            w_out_instr = imem_rdata;
            w_out_pc1   = w_pc_plus1;
            w_next_pc   = w_pc_plus1;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    // Reset must force a bubble even if memory happens to report ready.
    assign Instruction = rst ? w_out_instr : NOP_INSTR;
    assign PC_plus1    = rst ? w_out_pc1 : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory returns addr*3, NOP overridden to a distinct word.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam instr_t NOP = 32'h0000_0013;

    logic   clk = 1'b0;
    logic   rst;
    logic   stall;
    logic   redirect;
    addr_t  redirect_target;
    logic   imem_req;
    addr_t  imem_addr;
    logic   imem_ready;
    instr_t imem_rdata;
    addr_t  PC_plus1;
    instr_t Instruction;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    assign imem_rdata = instr_t'(imem_addr) * 32'd3;

    instruction_fetch #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .PC_plus1       (PC_plus1),
        .Instruction    (Instruction)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc1);
        check({tag, ".instr"}, Instruction, exp_instr);
        check({tag, ".pc1"}, 32'(PC_plus1), exp_pc1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0; imem_ready = 1'b1;
        #4;
        check_out("reset", NOP, 0);
        check("reset.req", 32'(imem_req), 1);
        check("reset.addr", 32'(imem_addr), 0);

        // Release away from the edge; fetch starts at RESET_PC with one instruction per cycle.
        tick(); rst = 1'b1; settle();
        check_out("seq0", 0, 1);
        tick(); settle(); check_out("seq1", 3, 2);
        tick(); settle(); check_out("seq2", 6, 3);
        tick(); settle(); check_out("seq3", 9, 4);
        tick(); settle(); check_out("seq4", 12, 5);

        // Memory not ready for two cycles at PC=5.
        tick(); imem_ready = 1'b0; settle();
        check_out("wait0", NOP, 0); check("wait0.addr", 32'(imem_addr), 5);
        tick(); settle();
        check_out("wait1", NOP, 0); check("wait1.addr", 32'(imem_addr), 5);
        tick(); imem_ready = 1'b1; settle(); check_out("wait_done", 15, 6);
        tick(); settle(); check_out("pc6", 18, 7);
        tick(); settle(); check_out("pc7", 21, 8);

        // Stall three cycles while ready at PC=8.
        tick(); stall = 1'b1; settle();
        check_out("stall0", 21, 8); check("stall0.req", 32'(imem_req), 1);
        tick(); settle();
        check_out("stall1", 21, 8); check("stall1.req", 32'(imem_req), 0);
        check("stall1.addr", 32'(imem_addr), 8);
        tick(); settle();
        check_out("stall2", 21, 8); check("stall2.req", 32'(imem_req), 0);
        tick(); stall = 1'b0; settle();
        check_out("unstall", 24, 9); check("unstall.addr", 32'(imem_addr), 8);
        tick(); settle();
        check_out("pc9", 27, 10); check("pc9.addr", 32'(imem_addr), 9);
        check("pc9.req", 32'(imem_req), 1);

        // Redirect while parked in S_HOLD discards the buffered word.
        tick(); stall = 1'b1; settle(); check_out("hold_in", 27, 10);
        tick(); redirect = 1'b1; redirect_target = 16'h0040; settle();
        check_out("redir", NOP, 0); check("redir.req", 32'(imem_req), 0);
        tick(); redirect = 1'b0; stall = 1'b0; settle();
        check("redir.addr", 32'(imem_addr), 32'h40); check_out("redir_fetch", 32'hC0, 32'h41);

        // Address wrap at all-ones.
        tick(); redirect = 1'b1; redirect_target = 16'hFFFF; settle(); check_out("wrap_redir", NOP, 0);
        tick(); redirect = 1'b0; settle();
        check("wrap.addr", 32'(imem_addr), 32'hFFFF); check_out("wrap", 32'h0002_FFFD, 0);
        tick(); settle();
        check("wrap_next.addr", 32'(imem_addr), 0); check_out("wrap_next", 0, 1);

        // Asynchronous reset in the middle of a stall at PC=12.
        tick(); redirect = 1'b1; redirect_target = 16'h000C; settle();
        tick(); redirect = 1'b0; stall = 1'b1; settle();
        check_out("pc12_stall", NOP, 0); check("pc12.addr", 32'(imem_addr), 12);
        tick(); settle(); check("pc12_hold.req", 32'(imem_req), 0);
        #1 rst = 1'b0; #1;
        check_out("async_rst", NOP, 0);
        check("async_rst.addr", 32'(imem_addr), 0); check("async_rst.req", 32'(imem_req), 1);
        tick(); rst = 1'b1; stall = 1'b0; settle();
        check_out("post_rst", 0, 1);
        tick(); settle(); check_out("post_rst1", 3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 0, instruction word presented as a bubble.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  hazard hold: present no new instruction this cycle.
REQ-006 SHALL have port redirect  input  1  taken branch/jump: squash and refetch.
REQ-007 SHALL have port redirect_target  input  ADDRESS_LEN  new PC when redirect=1.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  output  ADDRESS_LEN  fetch address, always equal to PC.
REQ-010 SHALL have port imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-011 SHALL have port imem_rdata  input  INSTRUCTION_LEN  fetched instruction word.
REQ-012 SHALL have port PC_plus1  output  ADDRESS_LEN  address of fetched instruction + 1, to IF/ID.
REQ-013 SHALL have port Instruction  output  INSTRUCTION_LEN  fetched instruction, to IF/ID.

Function
REQ-014 SHALL hold internal registers: PC, state {S_REQ, S_HOLD}, hold buffer (instr, pc_plus1), last-presented pair (instr, pc_plus1).
REQ-015 SHALL drive imem_req=1 in S_REQ, 0 in S_HOLD; imem_addr changes only after a ready handshake or a redirect.
REQ-016 Priority: redirect > stall > normal, evaluated every cycle.
REQ-017 redirect=1 (any state, any stall): outputs NOP_INSTR/0 this cycle; next edge PC<=redirect_target, state<=S_REQ, hold buffer discarded; an in-flight imem response in that cycle is dropped.
REQ-018 stall=1, redirect=0: Instruction/PC_plus1 SHALL equal the pair presented the previous cycle; PC unchanged.
REQ-019 stall=1 in S_REQ with imem_ready=1: capture (imem_rdata, PC+1) into hold buffer, state<=S_HOLD, PC unchanged.
REQ-020 stall=1 in S_HOLD: remain in S_HOLD, buffer unchanged.
REQ-021 stall=0 in S_HOLD: present buffer contents; next edge PC<=PC+1, state<=S_REQ.
REQ-022 stall=0 in S_REQ, imem_ready=1: present imem_rdata and PC+1 combinationally (zero added latency); next edge PC<=PC+1.
REQ-023 stall=0 in S_REQ, imem_ready=0: present NOP_INSTR/0 (bubble); PC unchanged.
REQ-024 Last-presented pair SHALL update every edge with the values presented that cycle.
REQ-025 PC+1 SHALL be computed modulo 2^ADDRESS_LEN (all-ones wraps to 0).
REQ-026 Sustained throughput: one instruction per cycle when imem_ready=1 every cycle and stall=0.

Reset
REQ-027 rst=0 SHALL immediately set PC=RESET_PC, state=S_REQ, hold buffer and last-presented pair to NOP_INSTR/0.
REQ-028 During reset Instruction=NOP_INSTR, PC_plus1=0, imem_req=1, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-handshake or in S_HOLD SHALL discard all fetch state; first fetch after release is RESET_PC.

Structure
REQ-030 ADDRESS_LEN and INSTRUCTION_LEN SHALL come from defines.sv; state enum SHALL live in shared package fetch_pkg.
REQ-031 Single module, no sub-modules; outputs feed PR_1 IF/ID register directly.

Verification
REQ-032 Reset release, imem_ready=1 constantly, rdata=addr*3: PC_plus1 sequence 1,2,3,4, Instruction 0,3,6,9 on consecutive cycles.
REQ-033 imem_ready low 2 cycles at PC=5: two NOP/0 outputs, imem_addr held 5, then instruction@5 with PC_plus1=6.
REQ-034 stall=1 for 3 cycles while ready at PC=8: outputs repeat prior pair, state S_HOLD, imem_req=0; on release instruction@8/9 presented, next fetch PC=9.
REQ-035 redirect=1 target 0x40 while stall=1 in S_HOLD: NOP/0 that cycle, buffer discarded, next imem_addr=0x40.
REQ-036 PC=all-ones, ready=1: PC_plus1=0, next imem_addr=0.
REQ-037 rst=0 asserted asynchronously mid-stall at PC=12: outputs NOP/0 immediately, first fetch after release at RESET_PC.
